// File: rtl/module_quant_ctrl_if.sv
// Control/data handshake bundle between a host and the requantisation sequencer.
// The host side (job control, table config, upstream acc stream) uses the master
// modport; the sequencer uses the slave modport.
interface module_quant_ctrl_if #(
    parameter int CH_AW = 6,
    parameter int PIX_W = 12
);
    // parameter-table write port
    logic                    cfg_we;
    logic [CH_AW-1:0]        cfg_addr;
    logic signed [15:0]      cfg_scale;
    logic [3:0]              cfg_shift;
    logic [7:0]              cfg_zp;
    // job control
    logic                    start;
    logic [CH_AW-1:0]        ch_base;
    logic [CH_AW:0]          ch_num;
    logic [PIX_W-1:0]        pix_num;
    logic                    busy;
    logic                    done;
    // upstream acc-group handshake
    logic                    in_valid;
    logic                    in_ready;
    // datapath parameters
    logic signed [15:0]      q_scale;
    logic [3:0]              q_shift;
    logic [7:0]              q_zero_point;
    // result tagging, aligned with the datapath output
    logic                    out_valid;
    logic [CH_AW-1:0]        out_ch;
    logic                    out_last_pix;
    logic                    out_last;

    modport master (
        output cfg_we, cfg_addr, cfg_scale, cfg_shift, cfg_zp,
        output start, ch_base, ch_num, pix_num, in_valid,
        input  busy, done, in_ready,
        input  q_scale, q_shift, q_zero_point,
        input  out_valid, out_ch, out_last_pix, out_last
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_scale, cfg_shift, cfg_zp,
        input  start, ch_base, ch_num, pix_num, in_valid,
        output busy, done, in_ready,
        output q_scale, q_shift, q_zero_point,
        output out_valid, out_ch, out_last_pix, out_last
    );
endinterface

// File: rtl/module_quant_ctrl.sv
// Sequencer for the 8-lane requantisation datapath. Holds a per-channel
// {scale, shift, zero_point} table, streams acc groups channel by channel,
// drains the datapath at every channel change so parameters never change
// under in-flight data, and tags results with channel / last flags that are
// delayed to line up with the datapath output.
module module_quant_ctrl #(
    parameter int CH_AW     = 6,
    parameter int PIX_W     = 12,
    parameter int QUANT_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    module_quant_ctrl_if.slave bus
);

    localparam int DEPTH = 1 << CH_AW;
    localparam int TBL_W = 16 + 4 + 8;
    // drain counter runs 0..QUANT_LAT-1
    localparam int DW    = (QUANT_LAT > 1) ? $clog2(QUANT_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CH_AW-1:0]     ch_idx_q;
    logic [CH_AW:0]       ch_left_q;
    logic [PIX_W-1:0]     pix_num_q;
    logic [PIX_W-1:0]     pix_cnt_q;
    logic [DW-1:0]        drain_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 in_ready_q;

    logic                 accept_d;
    logic                 last_pix_d;
    logic                 last_job_d;

    logic [TBL_W-1:0]     tbl_mem [DEPTH];
    logic [TBL_W-1:0]     rd_data_q;

    // in_ready_q is only ever high in RUN, so an accept implies RUN
    assign accept_d   = bus.in_valid & in_ready_q;
    assign last_pix_d = (pix_cnt_q == (pix_num_q - PIX_W'(1)));
    assign last_job_d = last_pix_d && (ch_left_q == (CH_AW+1)'(1));

    // Parameter table write port; config is frozen while a job runs
    always_ff @(posedge clk) begin
        if (bus.cfg_we && (state_q == S_IDLE)) begin
            tbl_mem[bus.cfg_addr] <= {bus.cfg_scale, bus.cfg_shift, bus.cfg_zp};
        end
    end

    // Table read register doubles as the q_* parameter register: it only
    // loads in LOAD, so the values hold through RUN/DRAIN and after the job
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (state_q == S_LOAD) begin
            rd_data_q <= tbl_mem[ch_idx_q];
        end
    end

    assign bus.q_scale      = rd_data_q[TBL_W-1 -: 16];
    assign bus.q_shift      = rd_data_q[11:8];
    assign bus.q_zero_point = rd_data_q[7:0];

    // Job sequencer with registered busy/done/in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_idx_q    <= '0;
            ch_left_q   <= '0;
            pix_num_q   <= '0;
            pix_cnt_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if ((bus.ch_num == '0) || (bus.pix_num == '0)) begin
                            // empty job: report completion without touching the datapath
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD;
                            ch_idx_q  <= bus.ch_base;
                            ch_left_q <= bus.ch_num;
                            pix_num_q <= bus.pix_num;
                            pix_cnt_q <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    state_q    <= S_RUN;
                    in_ready_q <= 1'b1;
                end
                S_RUN: begin
                    if (accept_d) begin
                        if (last_pix_d) begin
                            pix_cnt_q   <= '0;
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= S_DRAIN;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // wait until the channel's last group has left the datapath
                    if (drain_cnt_q == DW'(QUANT_LAT - 1)) begin
                        if (ch_left_q != (CH_AW+1)'(1)) begin
                            ch_left_q <= ch_left_q - (CH_AW+1)'(1);
                            ch_idx_q  <= ch_idx_q + CH_AW'(1);
                            state_q   <= S_LOAD;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.in_ready = in_ready_q;

    // Tag pipeline matching the datapath latency, one register stage per cycle
    for (genvar gi = 0; gi < QUANT_LAT; gi++) begin : g_stage
        logic             vld_q;
        logic             lp_q;
        logic             last_q;
        logic [CH_AW-1:0] ch_q;

        if (gi == 0) begin : g_head
            // stage 0 captures the tag of the group accepted this cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    lp_q   <= 1'b0;
                    last_q <= 1'b0;
                    ch_q   <= '0;
                end else begin
                    vld_q  <= accept_d;
                    lp_q   <= accept_d & last_pix_d;
                    last_q <= accept_d & last_job_d;
                    ch_q   <= ch_idx_q;
                end
            end
        end else begin : g_tail
            // later stages just shift the tag along
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    lp_q   <= 1'b0;
                    last_q <= 1'b0;
                    ch_q   <= '0;
                end else begin
                    vld_q  <= g_stage[gi-1].vld_q;
                    lp_q   <= g_stage[gi-1].lp_q;
                    last_q <= g_stage[gi-1].last_q;
                    ch_q   <= g_stage[gi-1].ch_q;
                end
            end
        end
    end

    assign bus.out_valid    = g_stage[QUANT_LAT-1].vld_q;
    assign bus.out_ch       = g_stage[QUANT_LAT-1].ch_q;
    assign bus.out_last_pix = g_stage[QUANT_LAT-1].lp_q;
    assign bus.out_last     = g_stage[QUANT_LAT-1].last_q;

endmodule

// File: tb/tb_module_quant_ctrl.sv
// Directed bench for module_quant_ctrl: table writes, multi-channel jobs,
// channel wrap, bubbles, empty jobs, ignored start/cfg while busy, mid-job reset.
module tb_module_quant_ctrl;

    localparam int CH_AW = 6;
    localparam int PIX_W = 12;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_quant_ctrl_if #(.CH_AW(CH_AW), .PIX_W(PIX_W)) bus ();

    module_quant_ctrl #(.CH_AW(CH_AW), .PIX_W(PIX_W), .QUANT_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          ch;
        bit          lp;
        bit          last;
        logic [15:0] sc;
        logic [3:0]  sh;
        logic [7:0]  zp;
        int          cyc;
    } beat_t;

    // table model
    logic [15:0] sc_m [64];
    logic [3:0]  sh_m [64];
    logic [7:0]  zp_m [64];

    beat_t beat_q [$];
    int    acc_q  [$];
    int    rdy_q  [$];
    int    acc_cnt, done_cnt, done_cyc, last_cyc, lat_err, orphan;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // observer: records accepts, result beats, in_ready cycles and done pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_q.push_back(cyc);
                acc_cnt++;
            end
            if (bus.out_valid) begin
                beat_t b;
                b.ch = int'(bus.out_ch); b.lp = bus.out_last_pix; b.last = bus.out_last;
                b.sc = bus.q_scale; b.sh = bus.q_shift; b.zp = bus.q_zero_point; b.cyc = cyc;
                beat_q.push_back(b);
                if (acc_q.size() == 0) orphan++;
                else if (cyc - acc_q.pop_front() != LAT) lat_err++;
                if (bus.out_last) last_cyc = cyc;
            end
            if (bus.in_ready) rdy_q.push_back(cyc);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic cfg_write(input int addr, input logic [15:0] sc, input logic [3:0] sh,
                             input logic [7:0] zp);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = CH_AW'(addr);
        bus.cfg_scale = sc; bus.cfg_shift = sh; bus.cfg_zp = zp;
        sc_m[addr] = sc; sh_m[addr] = sh; zp_m[addr] = zp;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic clear_obs();
        beat_q.delete(); acc_q.delete(); rdy_q.delete();
        acc_cnt = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; lat_err = 0; orphan = 0;
    endtask

    // toggle: in_valid flips every cycle; poke: start + cfg_we pulsed mid-job
    task automatic run_job(input int base, input int num, input int pix,
                           input bit toggle, input bit poke);
        int start_cyc, total, gaps, bad_gap, bad_sp, t, ech, lastch;
        clear_obs();
        total = num * pix;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ch_base = CH_AW'(base);
        bus.ch_num = (CH_AW+1)'(num); bus.pix_num = PIX_W'(pix);
        bus.in_valid = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (t = 0; t < 2000 && done_cnt == 0; t++) begin
            @(posedge clk); #1;
            if (toggle) bus.in_valid = ~bus.in_valid;
            if (poke && t == 2) begin
                bus.start = 1'b1; bus.ch_base = '0; bus.ch_num = 1; bus.pix_num = 1;
                bus.cfg_we = 1'b1; bus.cfg_addr = CH_AW'(base);
                bus.cfg_scale = 16'hDEAD; bus.cfg_shift = 4'h1; bus.cfg_zp = 8'h55;
            end
            if (poke && t == 3) begin
                bus.start = 1'b0; bus.cfg_we = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("job base=%0d ch=%0d pix=%0d toggle=%0d poke=%0d beats=%0d done=%0d",
                 base, num, pix, toggle, poke, beat_q.size(), done_cnt);
        check("done_count", done_cnt, 1);
        check("beat_count", beat_q.size(), total);
        check("latency", lat_err, 0);
        check("orphan_beats", orphan, 0);
        if (total == 0) begin
            check("done_empty_cyc", done_cyc, start_cyc + 1);
        end else begin
            check("done_after_last", done_cyc, last_cyc + 1);
            if (!toggle) check("first_beat_cyc", beat_q[0].cyc, start_cyc + 2 + LAT);
            for (int i = 0; i < beat_q.size() && i < total; i++) begin
                ech = (base + i / pix) % 64;
                check($sformatf("ch[%0d]", i), beat_q[i].ch, ech);
                check($sformatf("last_pix[%0d]", i), beat_q[i].lp, (i % pix) == pix - 1);
                check($sformatf("last[%0d]", i), beat_q[i].last, i == total - 1);
                check($sformatf("scale[%0d]", i), {16'h0, beat_q[i].sc}, {16'h0, sc_m[ech]});
                check($sformatf("shift[%0d]", i), beat_q[i].sh, sh_m[ech]);
                check($sformatf("zp[%0d]", i), beat_q[i].zp, zp_m[ech]);
            end
            gaps = 0; bad_gap = 0;
            for (int i = 1; i < rdy_q.size(); i++) begin
                if (rdy_q[i] - rdy_q[i-1] > 1) begin
                    gaps++;
                    if (rdy_q[i] - rdy_q[i-1] != LAT + 2) bad_gap++;
                end
            end
            check("rdy_gaps", gaps, num - 1);
            check("rdy_gap_len", bad_gap, 0);
            if (toggle) begin
                bad_sp = 0;
                for (int i = 1; i < beat_q.size(); i++)
                    if (beat_q[i].cyc - beat_q[i-1].cyc != 2) bad_sp++;
                check("bubble_spacing", bad_sp, 0);
            end
            lastch = (base + num - 1) % 64;
            check("q_hold", {16'h0, bus.q_scale}, {16'h0, sc_m[lastch]});
            check("busy_end", bus.busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_scale = '0; bus.cfg_shift = '0; bus.cfg_zp = '0;
        bus.start = 0; bus.ch_base = '0; bus.ch_num = '0; bus.pix_num = '0; bus.in_valid = 0;
        clear_obs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_q_scale", {16'h0, bus.q_scale}, 0);
        check("rst_out_last", bus.out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single channel, four groups
        cfg_write(5, 16'h1234, 4'd7, 8'd128);
        run_job(5, 1, 4, 0, 0);

        // 2: three channels, two groups each
        cfg_write(10, 16'h0101, 4'd1, 8'd10);
        cfg_write(11, 16'h8002, 4'd2, 8'd20);
        cfg_write(12, 16'h7FFF, 4'd15, 8'd255);
        run_job(10, 3, 2, 0, 0);

        // 3: channel index wraps 63 -> 0
        cfg_write(63, 16'hF00D, 4'd3, 8'd63);
        cfg_write(0,  16'h0BAD, 4'd9, 8'd1);
        run_job(63, 2, 2, 0, 0);

        // 4: bubbles in RUN
        run_job(5, 1, 4, 1, 0);

        // 5: empty jobs, start and cfg_we while busy
        run_job(7, 1, 0, 0, 0);
        run_job(7, 0, 4, 0, 0);
        run_job(5, 1, 4, 0, 1);
        run_job(5, 1, 1, 0, 0);

        // 6: reset in RUN after two accepts
        clear_obs();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ch_base = 6'd5; bus.ch_num = 1; bus.pix_num = 8; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int t = 0; t < 50 && acc_cnt < 2; t++) begin
            @(posedge clk); #1;
        end
        check("rst_job_accepts", acc_cnt >= 2, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_q_scale", {16'h0, bus.q_scale}, 0);
        check("midrst_out_last_pix", bus.out_last_pix, 0);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        clear_obs();
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_beats", beat_q.size(), 0);
        $display("reset mid-job done=%0d beats=%0d", done_cnt, beat_q.size());
        run_job(5, 1, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
